// File: rtl/l1_dcache_if.sv
// Signal bundles for the L1 data cache: the CPU request side and the
// line-granular physical memory side.

interface dcache_cpu_if;
  logic        dcache_read;
  logic        dcache_write;
  logic [1:0]  dcache_wmask;
  logic [15:0] dcache_address;
  logic [15:0] dcache_wdata;
  logic        dcache_resp;
  logic [15:0] dcache_rdata;

  modport master (
    output dcache_read, dcache_write, dcache_wmask, dcache_address, dcache_wdata,
    input  dcache_resp, dcache_rdata
  );

  modport slave (
    input  dcache_read, dcache_write, dcache_wmask, dcache_address, dcache_wdata,
    output dcache_resp, dcache_rdata
  );
endinterface

interface dcache_mem_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with zero-wait hits
// and a line-granular fill/writeback port.

module l1_dcache #(
  parameter int NUM_SETS  = 8,
  parameter int LINE_BITS = 128
) (
  input  logic         clk,
  input  logic         reset_n,
  dcache_cpu_if.slave  cpu_if,
  dcache_mem_if.master mem_if
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 16 - 4 - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_e;

  state_e               state_q;
  logic [NUM_SETS-1:0]  valid_q;
  logic [NUM_SETS-1:0]  dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_SETS];
  logic [LINE_BITS-1:0] data_q [NUM_SETS];

  // Miss target is latched so a dropped or changed request cannot redirect the fill.
  logic [IDX_W-1:0]     miss_idx_q;
  logic [TAG_W-1:0]     miss_tag_q;
  logic                 pmem_read_q;
  logic                 pmem_write_q;
  logic [15:0]          pmem_addr_q;

  logic                 req;
  logic                 hit;
  logic                 write_hit;
  logic [IDX_W-1:0]     req_idx;
  logic [TAG_W-1:0]     req_tag;
  logic [2:0]           word_sel;
  logic [6:0]           bit_base;
  logic [15:0]          cur_word;
  logic                 unused_addr_bit;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    req       = cpu_if.dcache_read | cpu_if.dcache_write;
    req_idx   = cpu_if.dcache_address[4 +: IDX_W];
    req_tag   = cpu_if.dcache_address[15 -: TAG_W];
    word_sel  = cpu_if.dcache_address[3:1];
    bit_base  = {word_sel, 4'b0000};
    cur_word  = data_q[req_idx][bit_base +: 16];
    hit       = 1'b0;
    if (valid_q[req_idx] && (tag_q[req_idx] == req_tag)) begin
      hit = 1'b1;
    end
    write_hit = (state_q == IDLE) && req && hit && cpu_if.dcache_write;
  end

  assign unused_addr_bit = cpu_if.dcache_address[0];

  // Control state, line status bits and the registered memory-side strobes.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      miss_idx_q   <= '0;
      miss_tag_q   <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      pmem_addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && hit) begin
            if (cpu_if.dcache_write && (cpu_if.dcache_wmask != 2'b00)) begin
              dirty_q[req_idx] <= 1'b1;
            end
          end else if (req) begin
            miss_idx_q <= req_idx;
            miss_tag_q <= req_tag;
            if (valid_q[req_idx] && dirty_q[req_idx]) begin
              state_q      <= WRITEBACK;
              pmem_write_q <= 1'b1;
              pmem_addr_q  <= {tag_q[req_idx], req_idx, 4'b0000};
            end else begin
              state_q      <= ALLOCATE;
              pmem_read_q  <= 1'b1;
              pmem_addr_q  <= {req_tag, req_idx, 4'b0000};
            end
          end
        end

        WRITEBACK: begin
          if (mem_if.pmem_resp) begin
            state_q      <= ALLOCATE;
            pmem_write_q <= 1'b0;
            pmem_read_q  <= 1'b1;
            pmem_addr_q  <= {miss_tag_q, miss_idx_q, 4'b0000};
          end
        end

        ALLOCATE: begin
          if (mem_if.pmem_resp) begin
            state_q              <= IDLE;
            pmem_read_q          <= 1'b0;
            pmem_addr_q          <= '0;
            valid_q[miss_idx_q]  <= 1'b1;
            dirty_q[miss_idx_q]  <= 1'b0;
          end
        end

        default: begin
          state_q      <= IDLE;
          pmem_read_q  <= 1'b0;
          pmem_write_q <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: tag and data arrays carry no reset; valid bits alone make their contents meaningful.
  always_ff @(posedge clk) begin
    if (write_hit) begin
      if (cpu_if.dcache_wmask[0]) begin
        data_q[req_idx][bit_base +: 8] <= cpu_if.dcache_wdata[7:0];
      end
      if (cpu_if.dcache_wmask[1]) begin
        data_q[req_idx][(bit_base + 7'd8) +: 8] <= cpu_if.dcache_wdata[15:8];
      end
    end else if ((state_q == ALLOCATE) && mem_if.pmem_resp) begin
      data_q[miss_idx_q] <= mem_if.pmem_rdata;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end
  end

  // Read data is gated by hit, so it reads zero while valid bits are held clear.
  assign cpu_if.dcache_resp  = (state_q == IDLE) && req && hit;
  assign cpu_if.dcache_rdata = ((state_q == IDLE) && hit) ? cur_word : 16'h0000;

  assign mem_if.pmem_read    = pmem_read_q;
  assign mem_if.pmem_write   = pmem_write_q;
  assign mem_if.pmem_address = pmem_addr_q;
  assign mem_if.pmem_wdata   = data_q[miss_idx_q];

endmodule

// File: tb/tb_l1_dcache.sv
// Self-checking bench for l1_dcache: directed scenarios plus randomized traffic
// against a flat-memory reference model and a behavioural line-memory responder.

module tb_l1_dcache;

  logic clk;
  logic reset_n;

  dcache_cpu_if cpu_if ();
  dcache_mem_if mem_if ();

  l1_dcache #(.NUM_SETS(8), .LINE_BITS(128)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cpu_if  (cpu_if),
    .mem_if  (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: CPU-visible 16-bit words, DRAM image, per-set line status.
  logic [15:0]  ref_word [int];
  logic [127:0] backing  [int];
  bit           mv [8];
  bit           md [8];
  logic [8:0]   mt [8];

  int           mem_latency = 3;
  int           busy = 0;
  int           fill_count = 0;
  int           wb_count = 0;
  logic [15:0]  last_fill_addr = '0;
  logic [15:0]  last_wb_addr = '0;
  logic [127:0] last_wb_data = '0;

  function automatic logic [15:0] init_word(int waddr);
    return 16'((waddr * 40503 + 12345) ^ (waddr >> 3));
  endfunction

  function automatic logic [15:0] ref_read(int waddr);
    if (ref_word.exists(waddr)) return ref_word[waddr];
    return init_word(waddr);
  endfunction

  function automatic logic [127:0] ref_line(int laddr);
    logic [127:0] l;
    for (int w = 0; w < 8; w++) l[16*w +: 16] = ref_read(laddr * 8 + w);
    return l;
  endfunction

  function automatic logic [127:0] mem_line(int laddr);
    logic [127:0] l;
    if (backing.exists(laddr)) return backing[laddr];
    for (int w = 0; w < 8; w++) l[16*w +: 16] = init_word(laddr * 8 + w);
    return l;
  endfunction

  // Line memory: answers a held strobe after mem_latency cycles with a one-cycle pulse.
  initial begin
    mem_if.pmem_resp  = 1'b0;
    mem_if.pmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_if.pmem_resp = 1'b0;
      if (mem_if.pmem_read || mem_if.pmem_write) begin
        busy++;
        if (busy >= mem_latency) begin
          int la;
          busy = 0;
          la = int'(mem_if.pmem_address >> 4);
          mem_if.pmem_resp = 1'b1;
          if (mem_if.pmem_write) begin
            backing[la]  = mem_if.pmem_wdata;
            last_wb_addr = mem_if.pmem_address;
            last_wb_data = mem_if.pmem_wdata;
            wb_count++;
          end else begin
            mem_if.pmem_rdata = mem_line(la);
            last_fill_addr    = mem_if.pmem_address;
            fill_count++;
          end
        end
      end else begin
        busy = 0;
      end
    end
  end

  // Bus rules that must hold on every cycle.
  always @(negedge clk) begin
    if (mem_if.pmem_read || mem_if.pmem_write || cpu_if.dcache_resp) begin
      checks++;
      if ((mem_if.pmem_read && mem_if.pmem_write) ||
          (cpu_if.dcache_resp && (mem_if.pmem_read || mem_if.pmem_write)) ||
          ((mem_if.pmem_read || mem_if.pmem_write) && (mem_if.pmem_address[3:0] != 4'h0))) begin
        errors++;
        $display("FAIL bus_rules t=%0t: rd=%b wr=%b resp=%b addr=%h", $time,
                 mem_if.pmem_read, mem_if.pmem_write, cpu_if.dcache_resp, mem_if.pmem_address);
      end
    end
  end

  task automatic drive_idle();
    cpu_if.dcache_read    = 1'b0;
    cpu_if.dcache_write   = 1'b0;
    cpu_if.dcache_wmask   = 2'b00;
    cpu_if.dcache_address = 16'h0000;
    cpu_if.dcache_wdata   = 16'h0000;
  endtask

  task automatic resync_after_reset();
    for (int i = 0; i < 8; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    ref_word.delete();
    foreach (backing[l]) begin
      for (int w = 0; w < 8; w++) ref_word[l * 8 + w] = backing[l][16*w +: 16];
    end
  endtask

  // One CPU access held until resp; every expectation comes from the reference model.
  task automatic access(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wd, input logic [1:0] wm,
                        input string name, output logic [15:0] got);
    int           idx        = int'(addr[6:4]);
    logic [8:0]   tg         = addr[15:7];
    int           waddr      = int'(addr >> 1);
    bit           exp_hit    = mv[idx] && (mt[idx] == tg);
    bit           exp_wb     = !exp_hit && mv[idx] && md[idx];
    logic [15:0]  exp_wb_adr = {mt[idx], addr[6:4], 4'h0};
    logic [127:0] exp_wb_dat = ref_line(int'({mt[idx], addr[6:4]}));
    logic [15:0]  exp_rdata  = ref_read(waddr);
    int           exp_waits  = exp_hit ? 0 : (exp_wb ? 2 * mem_latency + 1 : mem_latency + 1);
    int           f0 = fill_count;
    int           w0 = wb_count;
    int           waits = 0;
    bit           seen = 1'b0;

    got = 16'h0000;
    cpu_if.dcache_read    = rd;
    cpu_if.dcache_write   = wr;
    cpu_if.dcache_wmask   = wm;
    cpu_if.dcache_address = addr;
    cpu_if.dcache_wdata   = wd;
    while (!seen && waits < 200) begin
      @(negedge clk);
      if (cpu_if.dcache_resp) begin
        seen = 1'b1;
        got  = cpu_if.dcache_rdata;
      end else begin
        waits++;
      end
    end
    @(posedge clk);
    #1;
    drive_idle();

    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s resp_timeout: no dcache_resp within %0d cycles", name, waits);
    end
    checks++;
    if (waits != exp_waits) begin
      errors++;
      $display("FAIL %s latency: got %0d wait cycles, expected %0d", name, waits, exp_waits);
    end
    if (rd) begin
      checks++;
      if (got !== exp_rdata) begin
        errors++;
        $display("FAIL %s rdata @%h: got %h expected %h", name, addr, got, exp_rdata);
      end
    end
    checks++;
    if ((fill_count - f0) != (exp_hit ? 0 : 1) || (wb_count - w0) != (exp_wb ? 1 : 0)) begin
      errors++;
      $display("FAIL %s pmem_count: fills %0d wbs %0d, expected fills %0d wbs %0d", name,
               fill_count - f0, wb_count - w0, exp_hit ? 0 : 1, exp_wb ? 1 : 0);
    end
    if (!exp_hit) begin
      checks++;
      if (last_fill_addr !== {tg, addr[6:4], 4'h0}) begin
        errors++;
        $display("FAIL %s fill_addr: got %h expected %h", name, last_fill_addr, {tg, addr[6:4], 4'h0});
      end
    end
    if (exp_wb) begin
      checks++;
      if (last_wb_addr !== exp_wb_adr || last_wb_data !== exp_wb_dat) begin
        errors++;
        $display("FAIL %s writeback: addr %h data %h expected addr %h data %h", name,
                 last_wb_addr, last_wb_data, exp_wb_adr, exp_wb_dat);
      end
    end

    if (!exp_hit) begin
      mv[idx] = 1'b1;
      mt[idx] = tg;
      md[idx] = 1'b0;
    end
    if (wr && wm != 2'b00) begin
      logic [15:0] nw;
      nw = ref_read(waddr);
      if (wm[0]) nw[7:0]  = wd[7:0];
      if (wm[1]) nw[15:8] = wd[15:8];
      ref_word[waddr] = nw;
      md[idx] = 1'b1;
    end
  endtask

  task automatic wait_for_strobe(input string name);
    int n = 0;
    while (!(mem_if.pmem_read || mem_if.pmem_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(mem_if.pmem_read || mem_if.pmem_write)) begin
      errors++;
      $display("FAIL %s strobe_timeout: no pmem strobe within %0d cycles", name, n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_idle();
    for (int i = 0; i < 8; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
      mt[i] = '0;
    end
    #1;
    checks++;
    if (cpu_if.dcache_resp !== 1'b0 || mem_if.pmem_read !== 1'b0 ||
        mem_if.pmem_write !== 1'b0 || cpu_if.dcache_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: resp=%b rd=%b wr=%b rdata=%h, all expected 0",
               cpu_if.dcache_resp, mem_if.pmem_read, mem_if.pmem_write, cpu_if.dcache_rdata);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (mem_if.pmem_read !== 1'b0 || mem_if.pmem_write !== 1'b0 || cpu_if.dcache_resp !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: rd=%b wr=%b resp=%b expected 0",
               mem_if.pmem_read, mem_if.pmem_write, cpu_if.dcache_resp);
    end
  endtask

  task automatic test_cold_read();
    logic [127:0] l;
    logic [15:0]  got;
    l = mem_line(12'h123);
    l[47:32] = 16'hBEEF;
    l[63:48] = 16'h1357;
    backing[12'h123] = l;
    for (int w = 0; w < 8; w++) ref_word[12'h123 * 8 + w] = l[16*w +: 16];
    mem_latency = 3;
    access(1'b1, 1'b0, 16'h1234, 16'h0, 2'b00, "cold_read", got);
    checks++;
    if (got !== 16'hBEEF || last_fill_addr !== 16'h1230) begin
      errors++;
      $display("FAIL cold_read_values: rdata %h fill_addr %h expected BEEF 1230", got, last_fill_addr);
    end
    access(1'b1, 1'b0, 16'h1236, 16'h0, 2'b00, "hit_read", got);
    checks++;
    if (got !== 16'h1357) begin
      errors++;
      $display("FAIL hit_read_value: got %h expected 1357", got);
    end
  endtask

  task automatic test_write_hit();
    logic [15:0] got;
    access(1'b0, 1'b1, 16'h1234, 16'hA55A, 2'b01, "write_hit", got);
    access(1'b1, 1'b0, 16'h1234, 16'h0, 2'b00, "write_hit_readback", got);
    checks++;
    if (got !== 16'hBE5A) begin
      errors++;
      $display("FAIL write_hit_merge: got %h expected BE5A", got);
    end
  endtask

  task automatic test_dirty_evict();
    logic [15:0] got;
    mem_latency = 2;
    access(1'b1, 1'b0, 16'h1A34, 16'h0, 2'b00, "dirty_evict", got);
    checks++;
    if (last_wb_addr !== 16'h1230 || last_wb_data[47:32] !== 16'hBE5A || last_fill_addr !== 16'h1A30) begin
      errors++;
      $display("FAIL dirty_evict_values: wb_addr %h wb_word2 %h fill_addr %h expected 1230 BE5A 1A30",
               last_wb_addr, last_wb_data[47:32], last_fill_addr);
    end
    // An all-zero mask must complete without dirtying, so the next eviction is clean.
    access(1'b0, 1'b1, 16'h1A34, 16'hFFFF, 2'b00, "zero_mask_write", got);
    access(1'b1, 1'b0, 16'h1234, 16'h0, 2'b00, "clean_evict", got);
  endtask

  task automatic test_read_write_both();
    logic [15:0] got;
    access(1'b1, 1'b1, 16'h1234, 16'h0001, 2'b11, "rw_both", got);
    checks++;
    if (got !== 16'hBE5A) begin
      errors++;
      $display("FAIL rw_both_prewrite: got %h expected BE5A", got);
    end
    access(1'b1, 1'b0, 16'h1234, 16'h0, 2'b00, "rw_both_readback", got);
    checks++;
    if (got !== 16'h0001) begin
      errors++;
      $display("FAIL rw_both_write: got %h expected 0001", got);
    end
  endtask

  task automatic test_drop();
    logic [15:0] got;
    int          n = 0;
    bit          done = 1'b0;
    logic [15:0] a = 16'h4C42;
    mem_latency = 3;
    cpu_if.dcache_read    = 1'b1;
    cpu_if.dcache_address = a;
    wait_for_strobe("drop");
    @(posedge clk);
    #1;
    drive_idle();
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      checks++;
      if (cpu_if.dcache_resp !== 1'b0) begin
        errors++;
        $display("FAIL drop_no_resp: resp=%b after request dropped", cpu_if.dcache_resp);
      end
      if (!mem_if.pmem_read && !mem_if.pmem_write) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drop_complete: pmem transaction still open after %0d cycles", n);
    end
    @(posedge clk);
    #1;
    mv[4] = 1'b1;
    mt[4] = a[15:7];
    md[4] = 1'b0;
    access(1'b1, 1'b0, a, 16'h0, 2'b00, "drop_then_hit", got);
  endtask

  task automatic test_reset_mid_alloc();
    logic [15:0] got;
    mem_latency = 1000;
    cpu_if.dcache_read    = 1'b1;
    cpu_if.dcache_address = 16'h2234;
    wait_for_strobe("reset_mid");
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_if.pmem_read !== 1'b0 || mem_if.pmem_write !== 1'b0 ||
        cpu_if.dcache_resp !== 1'b0 || cpu_if.dcache_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_strobes: rd=%b wr=%b resp=%b rdata=%h expected all 0",
               mem_if.pmem_read, mem_if.pmem_write, cpu_if.dcache_resp, cpu_if.dcache_rdata);
    end
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    resync_after_reset();
    mem_latency = 2;
    access(1'b1, 1'b0, 16'h2234, 16'h0, 2'b00, "reread_after_reset", got);
  endtask

  task automatic test_random();
    logic [15:0] got;
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      logic [1:0]  kind;
      a = {7'h00, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
      kind = 2'($urandom_range(0, 3));
      mem_latency = $urandom_range(1, 4);
      access(kind != 2'd1, kind != 2'd0, a, 16'($urandom), 2'($urandom_range(0, 3)), "random", got);
    end
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_write_hit();
    test_dirty_evict();
    test_read_write_both();
    test_drop();
    test_reset_mid_alloc();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
